// File: rtl/loa_stream_accumulator.sv
// ---------------------------------------------------------------------------
// loa_stream_accumulator
//
// Purpose:
//   Accumulates a burst of operands using lower-part-OR (LOA) approximate
//   addition. The low APPROX bits of the running sum are formed by OR-ing,
//   and the remaining upper bits go through an exact carry-lookahead adder.
//   One result is returned per burst over a valid/ready handshake. This lets
//   the approximate adder be characterised under accumulation, as in FIR and
//   MAC datapaths.
//
// Parameters:
//   WIDTH  - operand width
//   ACC_W  - accumulator / result width (must exceed WIDTH)
//   APPROX - number of low bits combined by OR (0 = exact addition)
//   CNT_W  - width of the burst-length field
//
// Ports:
//   clk_i       - clock, rising edge
//   rstn_i      - asynchronous active-low reset
//   start_i     - begin a burst (sampled in IDLE only)
//   len_i       - operand count for the burst, sampled with start_i
//   in_valid_i  - data_i is valid
//   in_ready_o  - block accepts data_i this cycle (ACCUM)
//   data_i      - operand, zero-extended to ACC_W
//   out_valid_o - result_o / ovf_o are valid (DONE)
//   out_ready_i - consumer accepts the result
//   result_o    - approximate burst sum
//   ovf_o       - sticky carry-out of the accumulator MSB for this burst
//   busy_o      - high in ACCUM and DONE
// ---------------------------------------------------------------------------

// Exact adder used for the upper part of the LOA. Carries are formed from
// generate/propagate terms so the synthesis tool can build a lookahead tree.
module carry_lookahead_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] gen;
  logic [W-1:0] prop;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = prop[i] ^ carry;
      carry  = gen[i] | (prop[i] & carry);
    end
    cout = carry;
  end

endmodule

module loa_stream_accumulator #(
  parameter int WIDTH  = 32,
  parameter int ACC_W  = 40,
  parameter int APPROX = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] result_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int HI_W = ACC_W - APPROX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;

  logic [ACC_W-1:0] data_ext;
  logic [ACC_W-1:0] loa_sum;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout;
  logic             lo_carry;

  assign data_ext = {{(ACC_W-WIDTH){1'b0}}, data_i};

  // Low part: OR instead of add. The only information passed upward is the
  // AND of the two top approximate bits, a cheap guess at the real carry.
  generate
    if (APPROX == 0) begin : g_exact
      assign lo_carry = 1'b0;
    end else begin : g_loa
      assign loa_sum[APPROX-1:0] = acc[APPROX-1:0] | data_ext[APPROX-1:0];
      assign lo_carry            = acc[APPROX-1] & data_ext[APPROX-1];
    end
  endgenerate

  carry_lookahead_adder #(
    .W(HI_W)
  ) u_upper_adder (
    .a   (acc[ACC_W-1:APPROX]),
    .b   (data_ext[ACC_W-1:APPROX]),
    .cin (lo_carry),
    .sum (hi_sum),
    .cout(hi_cout)
  );

  assign loa_sum[ACC_W-1:APPROX] = hi_sum;

  // Burst control. acc and ovf drive the outputs directly: they only change
  // while out_valid_o is low (ACCUM) or at a new start, so the consumer never
  // sees a partial sum flagged as valid, and the last result lingers in IDLE.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            acc <= '0;
            ovf <= 1'b0;
            if (len_i != '0) begin
              count <= len_i;
              state <= ACCUM;
            end else begin
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (in_valid_i) begin
            acc   <= loa_sum;
            ovf   <= ovf | hi_cout;
            count <= count - 1'b1;
            if (count == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = (state == ACCUM);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state == ACCUM) || (state == DONE);
  assign result_o    = acc;
  assign ovf_o       = ovf;

endmodule

// File: tb/tb_loa_stream_accumulator.sv
// ---------------------------------------------------------------------------
// tb_loa_stream_accumulator
//
// Three instances share one input stream: the default LOA configuration
// (ACC_W=40, APPROX=8), an exact 40-bit accumulator (APPROX=0) and a narrow
// exact 33-bit accumulator that wraps easily. Each instance is compared with
// an arithmetic model of the LOA rule evaluated for its own parameters.
// ---------------------------------------------------------------------------
module tb_loa_stream_accumulator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ovf_a, busy_a;
  logic [39:0] result_a;
  logic        in_ready_b, out_valid_b, ovf_b, busy_b;
  logic [39:0] result_b;
  logic        in_ready_c, out_valid_c, ovf_c, busy_c;
  logic [32:0] result_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loa_stream_accumulator #(
    .WIDTH(32), .ACC_W(40), .APPROX(8), .CNT_W(8)
  ) dut_a (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .len_i(len),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .data_i(data),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .result_o(result_a), .ovf_o(ovf_a), .busy_o(busy_a)
  );

  loa_stream_accumulator #(
    .WIDTH(32), .ACC_W(40), .APPROX(0), .CNT_W(8)
  ) dut_b (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .len_i(len),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .data_i(data),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .result_o(result_b), .ovf_o(ovf_b), .busy_o(busy_b)
  );

  loa_stream_accumulator #(
    .WIDTH(32), .ACC_W(33), .APPROX(0), .CNT_W(8)
  ) dut_c (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .len_i(len),
    .in_valid_i(in_valid), .in_ready_o(in_ready_c), .data_i(data),
    .out_valid_o(out_valid_c), .out_ready_i(out_ready),
    .result_o(result_c), .ovf_o(ovf_c), .busy_o(busy_c)
  );

  // Advance one clock and settle just after the edge, where outputs are
  // sampled and the next inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: LOA sum from plain arithmetic on 64-bit integers.
  function automatic void model(input int accw, input int l, input logic [31:0] v[$],
                                output logic [63:0] res, output logic ovf);
    logic [63:0] acc, b, low, hi, lmask, hmask, cin;
    acc   = 64'd0;
    ovf   = 1'b0;
    lmask = (64'd1 << l) - 64'd1;
    hmask = (64'd1 << (accw - l)) - 64'd1;
    foreach (v[i]) begin
      b   = {32'd0, v[i]};
      low = (acc | b) & lmask;
      cin = (l > 0) ? ((acc >> (l - 1)) & (b >> (l - 1)) & 64'd1) : 64'd0;
      hi  = (acc >> l) + (b >> l) + cin;
      if ((hi >> (accw - l)) != 64'd0) ovf = 1'b1;
      acc = ((hi & hmask) << l) | low;
    end
    res = acc;
  endfunction

  // Start a burst and feed its operands, optionally idling in_valid for
  // gap_len cycles before operand gap_at. Leaves the bench just after the
  // edge that carried the last transfer.
  task automatic drive_burst(input int n, input logic [31:0] v[$], input int gap_at, input int gap_len);
    start = 1'b1;
    len   = n[7:0];
    step();
    start = 1'b0;
    for (int i = 0; i < v.size(); i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) step();
      end
      in_valid = 1'b1;
      data     = v[i];
      step();
    end
    in_valid = 1'b0;
    data     = 32'd0;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0; data = 32'd0; out_ready = 1'b0;
    #2;
    checks++;
    if ({in_ready_a, out_valid_a, busy_a, ovf_a, result_a} !== 44'd0) begin
      errors++; $display("[TB] FAIL reset_a: got %h expected 0", {in_ready_a, out_valid_a, busy_a, ovf_a, result_a});
    end
    checks++;
    if ({in_ready_c, out_valid_c, busy_c, ovf_c, result_c} !== 37'd0) begin
      errors++; $display("[TB] FAIL reset_c: got %h expected 0", {in_ready_c, out_valid_c, busy_c, ovf_c, result_c});
    end
    repeat (2) step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] v[$];
    v = {32'h1, 32'h2, 32'h4};
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    foreach (v[i]) begin
      checks++;
      if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
        errors++; $display("[TB] FAIL basic_ready%0d: got rdy=%b vld=%b expected rdy=1 vld=0", i, in_ready_a, out_valid_a);
      end
      in_valid = 1'b1; data = v[i];
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_valid: got vld=%b rdy=%b expected vld=1 rdy=0", out_valid_a, in_ready_a);
    end
    checks++;
    if (result_a !== 40'h7 || ovf_a !== 1'b0 || result_c !== 33'h7) begin
      errors++; $display("[TB] FAIL basic_result: got a=%h ovf=%b c=%h expected 7 0 7", result_a, ovf_a, result_c);
    end
    ack();
    checks++;
    if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || result_a !== 40'h7) begin
      errors++; $display("[TB] FAIL basic_idle: got vld=%b busy=%b res=%h expected 0 0 7", out_valid_a, busy_a, result_a);
    end
  endtask

  task automatic test_loa_or();
    logic [31:0] v[$];
    v = {32'hFF, 32'h01};
    drive_burst(2, v, -1, 0);
    checks++;
    if (out_valid_a !== 1'b1 || result_a !== 40'hFF || result_b !== 40'h100) begin
      errors++; $display("[TB] FAIL loa_or: got vld=%b a=%h b=%h expected 1 ff 100", out_valid_a, result_a, result_b);
    end
    ack();
    v = {32'h80, 32'h80};
    drive_burst(2, v, -1, 0);
    checks++;
    if (result_a !== 40'h180 || result_b !== 40'h100) begin
      errors++; $display("[TB] FAIL loa_cin: got a=%h b=%h expected 180 100", result_a, result_b);
    end
    ack();
  endtask

  task automatic test_stall();
    logic [31:0] v[$];
    v = {32'h10, 32'h20, 32'h30, 32'h40};
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    foreach (v[i]) begin
      if (i == 2) begin
        in_valid = 1'b0; data = 32'hDEAD_BEEF;
        for (int k = 0; k < 2; k++) begin
          step();
          checks++;
          if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || result_b !== 40'h30) begin
            errors++; $display("[TB] FAIL stall_hold%0d: got rdy=%b vld=%b b=%h expected 1 0 30", k, in_ready_a, out_valid_a, result_b);
          end
        end
      end
      in_valid = 1'b1; data = v[i];
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid_b !== 1'b1 || result_b !== 40'hA0 || result_c !== 33'hA0 || result_a !== 40'h70) begin
      errors++; $display("[TB] FAIL stall_result: got vld=%b b=%h c=%h a=%h expected 1 a0 a0 70", out_valid_b, result_b, result_c, result_a);
    end
    ack();
  endtask

  task automatic test_zero_len();
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || result_a !== 40'd0 || ovf_a !== 1'b0 || result_c !== 33'd0) begin
      errors++; $display("[TB] FAIL zero_len: got vld=%b a=%h ovf=%b c=%h expected 1 0 0 0", out_valid_a, result_a, ovf_a, result_c);
    end
    for (int k = 0; k < 5; k++) begin
      start = 1'b1; len = 8'd3; in_valid = 1'b1; data = 32'h1234;
      step();
      checks++;
      if (out_valid_a !== 1'b1 || busy_a !== 1'b1 || in_ready_a !== 1'b0 || result_a !== 40'd0) begin
        errors++; $display("[TB] FAIL zero_hold%0d: got vld=%b busy=%b rdy=%b a=%h expected 1 1 0 0", k, out_valid_a, busy_a, in_ready_a, result_a);
      end
    end
    start = 1'b0; in_valid = 1'b0; data = 32'd0;
    ack();
    checks++;
    if (out_valid_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_release: got vld=%b busy=%b expected 0 0", out_valid_a, busy_a);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v[$];
    logic [63:0] ra;
    logic oa;
    v = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    model(40, 8, v, ra, oa);
    drive_burst(3, v, -1, 0);
    checks++;
    if (result_c !== 33'h0_FFFF_FFFD || ovf_c !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_c: got %h ovf=%b expected 0fffffffd 1", result_c, ovf_c);
    end
    checks++;
    if (result_b !== 40'h2_FFFF_FFFD || ovf_b !== 1'b0 || result_a !== ra[39:0] || ovf_a !== oa) begin
      errors++; $display("[TB] FAIL wrap_ab: got b=%h a=%h/%b expected 2fffffffd %h/%b", result_b, result_a, ovf_a, ra[39:0], oa);
    end
    ack();
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    checks++;
    if (ovf_c !== 1'b0) begin
      errors++; $display("[TB] FAIL wrap_clear: got ovf=%b expected 0", ovf_c);
    end
    in_valid = 1'b1; data = 32'h1;
    step();
    in_valid = 1'b0;
    checks++;
    if (result_c !== 33'h1 || ovf_c !== 1'b0 || out_valid_c !== 1'b1) begin
      errors++; $display("[TB] FAIL wrap_next: got %h ovf=%b vld=%b expected 1 0 1", result_c, ovf_c, out_valid_c);
    end
    ack();
  endtask

  task automatic test_async_reset();
    logic [31:0] v[$];
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; data = 32'h3;
    step();
    data = 32'h4;
    step();
    in_valid = 1'b0;
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if ({in_ready_a, out_valid_a, busy_a, ovf_a, result_a} !== 44'd0 || result_b !== 40'd0) begin
      errors++; $display("[TB] FAIL async_reset: got %h b=%h expected 0", {in_ready_a, out_valid_a, busy_a, ovf_a, result_a}, result_b);
    end
    repeat (2) step();
    rstn = 1'b1;
    step();
    checks++;
    if (busy_a !== 1'b0 || in_ready_a !== 1'b0 || out_valid_a !== 1'b0) begin
      errors++; $display("[TB] FAIL post_reset_idle: got busy=%b rdy=%b vld=%b expected 0 0 0", busy_a, in_ready_a, out_valid_a);
    end
    v = {32'h5};
    drive_burst(1, v, -1, 0);
    checks++;
    if (out_valid_a !== 1'b1 || result_a !== 40'h5 || result_c !== 33'h5) begin
      errors++; $display("[TB] FAIL post_reset_burst: got vld=%b a=%h c=%h expected 1 5 5", out_valid_a, result_a, result_c);
    end
    ack();
  endtask

  task automatic test_random();
    logic [31:0] v[$];
    logic [63:0] ra, rb, rc;
    logic oa, ob, oc;
    int n;
    int gap_at;
    for (int t = 0; t < 30; t++) begin
      n = int'($urandom_range(0, 12));
      v.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: v.push_back($urandom & 32'h0000_00FF);
          1: v.push_back($urandom | 32'hF000_0000);
          default: v.push_back($urandom);
        endcase
      end
      model(40, 8, v, ra, oa);
      model(40, 0, v, rb, ob);
      model(33, 0, v, rc, oc);
      gap_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 11)) : -1;
      drive_burst(n, v, gap_at, int'($urandom_range(1, 3)));
      checks++;
      if (out_valid_a !== 1'b1 || result_a !== ra[39:0] || ovf_a !== oa) begin
        errors++; $display("[TB] FAIL rand_a%0d: got vld=%b %h/%b expected 1 %h/%b", t, out_valid_a, result_a, ovf_a, ra[39:0], oa);
      end
      checks++;
      if (result_b !== rb[39:0] || ovf_b !== ob) begin
        errors++; $display("[TB] FAIL rand_b%0d: got %h/%b expected %h/%b", t, result_b, ovf_b, rb[39:0], ob);
      end
      checks++;
      if (result_c !== rc[32:0] || ovf_c !== oc) begin
        errors++; $display("[TB] FAIL rand_c%0d: got %h/%b expected %h/%b", t, result_c, ovf_c, rc[32:0], oc);
      end
      repeat ($urandom_range(0, 3)) step();
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_loa_or();
    test_stall();
    test_zero_len();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
